// File: rtl/rng_walk_arbiter.sv
// rng_walk_arbiter: round-robin sharing of one free-running LFSR among
// N_REQ random-walk engines. Each grant captures the LFSR sample and turns
// it into a uniform neighbour index in [0, degree) and a teleport decision
// against cfg_alpha. Results appear two clocks after the grant cycle.
// Optional feature: define RNG_ARB_PERF_EN to add per-requester grant
// counters readable through perf_sel / perf_cnt (1-cycle read latency).
module rng_walk_arbiter #(
   parameter int N_REQ = 4,
   parameter int DEG_W = 16,
   parameter int ID_W  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              lfsr_q,
   input  logic                     en,
   input  logic [15:0]              cfg_alpha,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*DEG_W-1:0]   req_deg,
   output logic [N_REQ-1:0]         gnt,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [DEG_W-1:0]         rsp_idx,
   output logic                     rsp_teleport,
   output logic                     rsp_dangling
`ifdef RNG_ARB_PERF_EN
   ,
   input  logic [ID_W-1:0]          perf_sel,
   output logic [31:0]              perf_cnt
`endif
);

   localparam int PW = 16 + DEG_W;

   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  win_id, cand;
   logic             win_found, grant;
   logic [DEG_W-1:0] deg_sel;

   logic             v1_q, v1_d;
   logic [31:0]      q1_q, q1_d;
   logic [DEG_W-1:0] deg1_q, deg1_d;
   logic [15:0]      alpha1_q, alpha1_d;
   logic [ID_W-1:0]  id1_q, id1_d;

   logic             rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic [DEG_W-1:0] rsp_idx_q, rsp_idx_d;
   logic             rsp_teleport_q, rsp_teleport_d;
   logic             rsp_dangling_q, rsp_dangling_d;
   logic [PW-1:0]    prod;
   logic             dangling;

   // Round-robin search starting one past the last winner, wrapping at N_REQ-1
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = ID_W'((32'(ptr_q) + i) % N_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
      grant = win_found && en && !reset;
      gnt   = '0;
      if (grant) gnt[win_id] = 1'b1;
      ptr_d   = grant ? win_id : ptr_q;
      deg_sel = req_deg[win_id*DEG_W +: DEG_W];
   end

   // Stage 1 capture: sample, degree, alpha and id are frozen at the grant
   always_comb begin
      v1_d     = grant;
      q1_d     = q1_q;
      deg1_d   = deg1_q;
      alpha1_d = alpha1_q;
      id1_d    = id1_q;
      if (grant) begin
         q1_d     = lfsr_q;
         deg1_d   = deg_sel;
         alpha1_d = cfg_alpha;
         id1_d    = win_id;
      end
   end

   // Stage 2 result: scaled index, teleport compare, dangling override
   always_comb begin
      prod           = PW'(q1_q[15:0]) * PW'(deg1_q);
      dangling       = (deg1_q == '0);
      rsp_valid_d    = v1_q;
      rsp_id_d       = rsp_id_q;
      rsp_idx_d      = rsp_idx_q;
      rsp_teleport_d = rsp_teleport_q;
      rsp_dangling_d = rsp_dangling_q;
      if (v1_q) begin
         rsp_id_d       = id1_q;
         rsp_idx_d      = dangling ? '0 : DEG_W'(prod >> 16);
         rsp_teleport_d = dangling || (q1_q[31:16] < alpha1_q);
         rsp_dangling_d = dangling;
      end
   end

   // Pointer and pipeline registers; reset discards in-flight results
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q          <= ID_W'(N_REQ - 1);
         v1_q           <= 1'b0;
         q1_q           <= '0;
         deg1_q         <= '0;
         alpha1_q       <= '0;
         id1_q          <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= '0;
         rsp_idx_q      <= '0;
         rsp_teleport_q <= 1'b0;
         rsp_dangling_q <= 1'b0;
      end else begin
         ptr_q          <= ptr_d;
         v1_q           <= v1_d;
         q1_q           <= q1_d;
         deg1_q         <= deg1_d;
         alpha1_q       <= alpha1_d;
         id1_q          <= id1_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_idx_q      <= rsp_idx_d;
         rsp_teleport_q <= rsp_teleport_d;
         rsp_dangling_q <= rsp_dangling_d;
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_idx      = rsp_idx_q;
   assign rsp_teleport = rsp_teleport_q;
   assign rsp_dangling = rsp_dangling_q;

`ifdef RNG_ARB_PERF_EN
   logic [31:0] cnt_q [N_REQ];
   logic [31:0] cnt_d [N_REQ];
   logic [31:0] perf_cnt_q, perf_cnt_d;

   // Grant counters (wrap naturally) and registered readback mux
   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cnt_d[i] = cnt_q[i] + ((grant && (win_id == ID_W'(i))) ? 32'd1 : 32'd0);
      end
      perf_cnt_d = '0;
      if (32'(perf_sel) < N_REQ) perf_cnt_d = cnt_q[perf_sel];
   end

   // Counter and readback registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
         perf_cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
         perf_cnt_q <= perf_cnt_d;
      end
   end

   assign perf_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_rng_walk_arbiter.sv
// Bench for rng_walk_arbiter: directed scenarios plus randomized walkers,
// checked against a queue-based reference model of the arbiter/result path.
module tb_rng_walk_arbiter;

   localparam int N = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   lfsr_q;
   logic          en;
   logic [15:0]   cfg_alpha;
   logic [N-1:0]  req;
   logic [N*DW-1:0] req_deg;
   logic [N-1:0]  gnt;
   logic          rsp_valid;
   logic [1:0]    rsp_id;
   logic [DW-1:0] rsp_idx;
   logic          rsp_teleport;
   logic          rsp_dangling;
`ifdef RNG_ARB_PERF_EN
   logic [1:0]    perf_sel;
   logic [31:0]   perf_cnt;
`endif

   rng_walk_arbiter #(.N_REQ(N), .DEG_W(DW), .ID_W(2)) dut (
      .clk(clk), .reset(reset), .lfsr_q(lfsr_q), .en(en), .cfg_alpha(cfg_alpha),
      .req(req), .req_deg(req_deg), .gnt(gnt), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_idx(rsp_idx), .rsp_teleport(rsp_teleport),
      .rsp_dangling(rsp_dangling)
`ifdef RNG_ARB_PERF_EN
      , .perf_sel(perf_sel), .perf_cnt(perf_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int id;
      int idx;
      bit tel;
      bit dang;
   } resp_t;

   resp_t pq[$];     // model: results still in flight
   resp_t got[$];    // results observed from the DUT
   int    n_err = 0;
   int    n_checks = 0;
   int    cyc = 0;
   int    mptr = N - 1;
   bit    last_g;
   int    last_gid;
   logic [N-1:0] last_gnt_obs;
   bit    last_v_obs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs are already set at the negedge; sample, compare, advance
   task automatic step();
      bit g;
      int gid;
      resp_t r;
      logic [31:0] q;
      logic [15:0] d;
      #1;
      g = 0;
      gid = 0;
      if (en && !reset) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (mptr + k) % N;
            if (!g && req[j]) begin
               g = 1;
               gid = j;
            end
         end
      end
      check("gnt", {28'd0, gnt}, g ? (32'd1 << gid) : 32'd0);
      last_gnt_obs = gnt;
      last_v_obs = rsp_valid;
      if (rsp_valid === 1'b1) begin
         r.due = cyc; r.id = int'(rsp_id); r.idx = int'(rsp_idx);
         r.tel = rsp_teleport; r.dang = rsp_dangling;
         got.push_back(r);
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
         r = pq.pop_front();
         check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("rsp_id", {30'd0, rsp_id}, r.id);
         check("rsp_idx", {16'd0, rsp_idx}, r.idx);
         check("rsp_teleport", {31'd0, rsp_teleport}, {31'd0, r.tel});
         check("rsp_dangling", {31'd0, rsp_dangling}, {31'd0, r.dang});
      end else begin
         check("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
      end
      if (g) begin
         q = lfsr_q;
         d = req_deg[gid*DW +: DW];
         r.due  = cyc + 2;
         r.id   = gid;
         r.dang = (d == 0);
         r.idx  = int'((longint'(q[15:0]) * longint'(d)) / 65536);
         r.tel  = (d == 0) || (q[31:16] < cfg_alpha);
         pq.push_back(r);
         mptr = gid;
      end
      last_g = g;
      last_gid = gid;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   function automatic logic [15:0] rdeg();
      case ($urandom_range(0, 7))
         0: rdeg = 16'h0000;
         1: rdeg = 16'hFFFF;
         2: rdeg = 16'h0001;
         default: rdeg = 16'($urandom);
      endcase
   endfunction

   function automatic logic [15:0] ralpha();
      case ($urandom_range(0, 3))
         0: ralpha = 16'h0000;
         1: ralpha = 16'hFFFF;
         default: ralpha = 16'($urandom);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int nv;
      reset = 1'b1; en = 1'b1; req = 4'b1111; req_deg = '0;
      lfsr_q = 32'h1234_5678; cfg_alpha = 16'h8000;
`ifdef RNG_ARB_PERF_EN
      perf_sel = 2'd0;
`endif
      #3;
      check("rst_gnt", {28'd0, gnt}, 0);
      check("rst_valid", {31'd0, rsp_valid}, 0);
      check("rst_id", {30'd0, rsp_id}, 0);
      check("rst_idx", {16'd0, rsp_idx}, 0);
      check("rst_tel", {31'd0, rsp_teleport}, 0);
      check("rst_dang", {31'd0, rsp_dangling}, 0);
      @(negedge clk);
      reset = 1'b0;

      // Round-robin fairness with all requests held
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < N; i++) req_deg[i*DW +: DW] = 16'(100 + i);
         lfsr_q = $urandom;
         step();
         check("rr_seq", {28'd0, last_gnt_obs}, 32'd1 << (k % 4));
      end

      // Index math
      req = 4'b0001; req_deg[0 +: DW] = 16'd10; lfsr_q = 32'h8000_4000; cfg_alpha = 16'h2000;
      step();
      req = 4'b0000; lfsr_q = $urandom;
      step();
      step();
      check("idx_math_idx", got[got.size()-1].idx, 2);
      check("idx_math_tel", {31'd0, got[got.size()-1].tel}, 0);

      // Teleport edges
      req = 4'b0010; req_deg[1*DW +: DW] = 16'd100; lfsr_q = 32'hFFFF_1234; cfg_alpha = 16'hFFFF;
      step();
      req = 4'b0100; req_deg[2*DW +: DW] = 16'd7; lfsr_q = 32'h1FFF_0000; cfg_alpha = 16'h2000;
      step();
      req = 4'b1000; req_deg[3*DW +: DW] = 16'd50; lfsr_q = 32'h0000_8000; cfg_alpha = 16'h0000;
      step();
      req = 4'b0000; lfsr_q = $urandom;
      step();
      step();
      check("tel_ffff", {31'd0, got[got.size()-3].tel}, 0);
      check("tel_1fff", {31'd0, got[got.size()-2].tel}, 1);
      check("tel_alpha0", {31'd0, got[got.size()-1].tel}, 0);
      check("tel_alpha0_idx", got[got.size()-1].idx, 25);

      // Degree 0 and maximum degree
      req = 4'b0100; req_deg[2*DW +: DW] = 16'd0; lfsr_q = 32'hFFFF_FFFF; cfg_alpha = 16'h0000;
      step();
      req = 4'b0001; req_deg[0 +: DW] = 16'hFFFF; lfsr_q = 32'hFFFF_FFFF; cfg_alpha = 16'h0000;
      step();
      req = 4'b0000;
      step();
      step();
      check("deg0_id", got[got.size()-2].id, 2);
      check("deg0_idx", got[got.size()-2].idx, 0);
      check("deg0_dang", {31'd0, got[got.size()-2].dang}, 1);
      check("deg0_tel", {31'd0, got[got.size()-2].tel}, 1);
      check("degmax_idx", got[got.size()-1].idx, 32'hFFFE);

      // Skip over idle requesters, then en=0 drains the pipeline
      req = 4'b0010; lfsr_q = $urandom;
      step();
      req = 4'b1010; lfsr_q = $urandom;
      step();
      check("skip_gnt3", {28'd0, last_gnt_obs}, 32'b1000);
      req = 4'b0010; lfsr_q = $urandom;
      step();
      check("skip_gnt1", {28'd0, last_gnt_obs}, 32'b0010);
      en = 1'b0; req = 4'b1111;
      nv = 0;
      for (int k = 0; k < 3; k++) begin
         lfsr_q = $urandom;
         step();
         check("en0_gnt", {28'd0, last_gnt_obs}, 0);
         nv += int'(last_v_obs);
      end
      check("en0_drain", nv, 2);
      en = 1'b1; req = 4'b0000;

      // Randomized walkers
      for (int k = 0; k < 400; k++) begin
         lfsr_q = $urandom;
         cfg_alpha = ralpha();
         en = ($urandom_range(0, 7) != 0);
         step();
         for (int i = 0; i < N; i++) begin
            if (last_g && last_gid == i) begin
               req[i] = ($urandom_range(0, 3) == 0);
               req_deg[i*DW +: DW] = rdeg();
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               req_deg[i*DW +: DW] = rdeg();
            end
         end
      end
      en = 1'b1; req = 4'b0000;
      step();
      step();

      // Asynchronous reset with two results in flight
      req = 4'b1111;
      lfsr_q = $urandom;
      step();
      lfsr_q = $urandom;
      step();
      #1;
      check("pre_rst_valid", {31'd0, rsp_valid}, 1);
      reset = 1'b1;
      #1;
      check("async_rst_valid", {31'd0, rsp_valid}, 0);
      check("async_rst_gnt", {28'd0, gnt}, 0);
      @(posedge clk);
      @(negedge clk);
      check("rst_hold_valid", {31'd0, rsp_valid}, 0);
      pq.delete();
      mptr = N - 1;
      req = 4'b0000;
      reset = 1'b0;
`ifdef RNG_ARB_PERF_EN
      for (int i = 0; i < N; i++) begin
         perf_sel = 2'(i);
         @(negedge clk);
         check("perf_cnt_rst", perf_cnt, 0);
      end
`endif
      req = 4'b1111; lfsr_q = $urandom;
      step();
      check("post_rst_gnt", {28'd0, last_gnt_obs}, 32'b0001);
      req = 4'b0000;
      step();
      step();
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
